// File: rtl/cic_vco_diff_ctrl.sv
// cic_vco_diff_ctrl
// Measurement sequencer for the differential VCO-ADC CIC decimation filter.
// A conversion request holds the filter in reset for two cycles, enables it,
// discards DISCARD settling ticks and sums 2^LOG2_AVG decimated samples.
// The block sum is then offered on a valid/ready handshake.
//
// Optional feature macro: CIC_CTRL_OFFSET_CAL_EN
//   When defined, START with CAL=1 stores the block sum as an offset. Normal
//   runs then return the saturated value sum - offset.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_start       conversion request, sampled only in IDLE
//   i_abort       cancel the conversion in progress
//   i_cal         qualifies i_start as offset calibration (feature build only)
//   i_cic_out     signed filter output, BW+1 bits
//   o_cic_res     high holds the filter in reset
//   o_cic_enable  filter enable
//   o_result      signed block sum, BW+1+LOG2_AVG bits
//   o_valid       o_result valid
//   i_ready       consumer accepts o_result
//   o_busy        sequencer not idle
module cic_vco_diff_ctrl #(
  parameter int unsigned BW       = 5,
  parameter int unsigned DEC      = 8,
  parameter int unsigned DISCARD  = 4,
  parameter int unsigned LOG2_AVG = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic                    i_cal,
  input  logic [BW:0]             i_cic_out,
  output logic                    o_cic_res,
  output logic                    o_cic_enable,
  output logic [BW+LOG2_AVG:0]    o_result,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_busy
);

  localparam int unsigned AW   = BW + 1 + LOG2_AVG;
  localparam int unsigned NAVG = 1 << LOG2_AVG;
  localparam int unsigned CMAX = (DISCARD > NAVG) ? DISCARD : NAVG;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned DW   = $clog2(DEC);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DEC - 1);
  localparam logic [CW-1:0] DISC_LAST = CW'(DISCARD - 1);
  localparam logic [CW-1:0] AVG_LAST  = CW'(NAVG - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StSettle,
    StAccum,
    StHold
  } state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic                  r_flush;
  logic                  w_flush_d;
  logic [DW-1:0]         r_div;
  logic [DW-1:0]         w_div_d;
  logic [CW-1:0]         r_tick_cnt;
  logic [CW-1:0]         w_tick_cnt_d;
  logic signed [AW-1:0]  r_acc;
  logic signed [AW-1:0]  w_acc_d;
  logic [AW-1:0]         r_result;
  logic [AW-1:0]         w_result_d;

  logic                  w_tick;
  logic signed [BW:0]    w_cic_s;
  logic signed [AW-1:0]  w_cic_ext;
  logic signed [AW-1:0]  w_sum;

  assign w_tick    = (r_div == DIV_LAST);
  assign w_cic_s   = i_cic_out;
  assign w_cic_ext = AW'(w_cic_s);
  // Accumulator width covers 2^LOG2_AVG full-scale samples, so no overflow.
  assign w_sum     = r_acc + w_cic_ext;

`ifdef CIC_CTRL_OFFSET_CAL_EN
  localparam logic [AW-1:0] RES_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] RES_MIN = {1'b1, {(AW-1){1'b0}}};

  logic                  r_cal;
  logic                  w_cal_d;
  logic signed [AW-1:0]  r_offset;
  logic signed [AW-1:0]  w_offset_d;
  logic signed [AW:0]    w_diff;
  logic [AW-1:0]         w_sat;

  // One guard bit: the two top bits disagree exactly when sum - offset leaves range.
  assign w_diff = (AW+1)'(w_sum) - (AW+1)'(r_offset);
  assign w_sat  = (w_diff[AW] != w_diff[AW-1]) ? (w_diff[AW] ? RES_MIN : RES_MAX)
                                               : w_diff[AW-1:0];
`else
  logic w_unused_cal;
  assign w_unused_cal = i_cal;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_flush    <= 1'b0;
      r_div      <= '0;
      r_tick_cnt <= '0;
      r_acc      <= '0;
      r_result   <= '0;
`ifdef CIC_CTRL_OFFSET_CAL_EN
      r_cal      <= 1'b0;
      r_offset   <= '0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_flush    <= w_flush_d;
      r_div      <= w_div_d;
      r_tick_cnt <= w_tick_cnt_d;
      r_acc      <= w_acc_d;
      r_result   <= w_result_d;
`ifdef CIC_CTRL_OFFSET_CAL_EN
      r_cal      <= w_cal_d;
      r_offset   <= w_offset_d;
`endif
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_flush_d    = r_flush;
    w_div_d      = r_div;
    w_tick_cnt_d = r_tick_cnt;
    w_acc_d      = r_acc;
    w_result_d   = r_result;
`ifdef CIC_CTRL_OFFSET_CAL_EN
    w_cal_d      = r_cal;
    w_offset_d   = r_offset;
`endif

    unique case (r_state)
      StIdle: begin
        if (i_start && !i_abort) begin
          w_state_d = StFlush;
          w_flush_d = 1'b0;
`ifdef CIC_CTRL_OFFSET_CAL_EN
          w_cal_d   = i_cal;
`endif
        end
      end

      StFlush: begin
        w_flush_d = 1'b1;
        if (r_flush) begin
          w_state_d    = StSettle;
          w_flush_d    = 1'b0;
          w_div_d      = '0;
          w_tick_cnt_d = '0;
        end
      end

      StSettle: begin
        w_div_d = w_tick ? '0 : r_div + 1'b1;
        if (w_tick) begin
          if (r_tick_cnt == DISC_LAST) begin
            w_state_d    = StAccum;
            w_tick_cnt_d = '0;
            w_acc_d      = '0;
          end else begin
            w_tick_cnt_d = r_tick_cnt + 1'b1;
          end
        end
      end

      StAccum: begin
        w_div_d = w_tick ? '0 : r_div + 1'b1;
        if (w_tick) begin
          w_acc_d = w_sum;
          if (r_tick_cnt == AVG_LAST) begin
            w_tick_cnt_d = '0;
            w_div_d      = '0;
`ifdef CIC_CTRL_OFFSET_CAL_EN
            if (r_cal) begin
              w_offset_d = w_sum;
              w_cal_d    = 1'b0;
              w_state_d  = StIdle;
            end else begin
              w_result_d = w_sat;
              w_state_d  = StHold;
            end
`else
            w_result_d = w_sum;
            w_state_d  = StHold;
`endif
          end else begin
            w_tick_cnt_d = r_tick_cnt + 1'b1;
          end
        end
      end

      StHold: begin
        if (i_ready) begin
          w_state_d = StIdle;
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Abort overrides everything except in IDLE; the last result is kept.
    if (i_abort && (r_state != StIdle)) begin
      w_state_d    = StIdle;
      w_flush_d    = 1'b0;
      w_div_d      = '0;
      w_tick_cnt_d = '0;
      w_acc_d      = '0;
`ifdef CIC_CTRL_OFFSET_CAL_EN
      w_cal_d      = 1'b0;
`endif
    end
  end

  always_comb begin
    o_cic_res    = 1'b1;
    o_cic_enable = 1'b0;
    if ((r_state == StSettle) || (r_state == StAccum)) begin
      o_cic_res    = 1'b0;
      o_cic_enable = 1'b1;
    end
  end

  assign o_valid  = (r_state == StHold);
  assign o_busy   = (r_state != StIdle);
  assign o_result = r_result;

endmodule

// File: tb/tb_cic_vco_diff_ctrl.sv
// Self-checking bench for cic_vco_diff_ctrl. Non-tick cycles carry random
// CIC_OUT noise; the model sums only the values present on the capture edges
// predicted from the sequence timing and compares the handshake result.
module tb_cic_vco_diff_ctrl;

  localparam int BW       = 5;
  localparam int DEC      = 8;
  localparam int DISCARD  = 4;
  localparam int LOG2_AVG = 3;
  localparam int NAVG     = 1 << LOG2_AVG;
  localparam int AW       = BW + 1 + LOG2_AVG;
  localparam int LAT      = 3 + DEC * (DISCARD + NAVG);
  localparam longint RMAX = (longint'(1) << (AW - 1)) - 1;
  localparam longint RMIN = -(longint'(1) << (AW - 1));

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic          i_abort;
  logic          i_cal;
  logic [BW:0]   i_cic_out;
  logic          o_cic_res;
  logic          o_cic_enable;
  logic [AW-1:0] o_result;
  logic          o_valid;
  logic          i_ready;
  logic          o_busy;

  int     n_checks = 0;
  int     n_errors = 0;
  longint model_offset = 0;
  longint last_result = 0;

  always #5 clk = ~clk;

  cic_vco_diff_ctrl #(
    .BW      (BW),
    .DEC     (DEC),
    .DISCARD (DISCARD),
    .LOG2_AVG(LOG2_AVG)
  ) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_cal       (i_cal),
    .i_cic_out   (i_cic_out),
    .o_cic_res   (o_cic_res),
    .o_cic_enable(o_cic_enable),
    .o_result    (o_result),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_busy      (o_busy)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint clamp(input longint x);
    if (x > RMAX) return RMAX;
    if (x < RMIN) return RMIN;
    return x;
  endfunction

  // mode 0: constant cval on ticks, 1: 31/-32 alternating per tick, 2: random.
  task automatic run_conv(input string tag, input int mode, input int cval, input bit cal,
                          input int ready_lat, input int abort_at, input int rst_at,
                          input bit chk_const, input longint exp_const);
    longint sum;
    longint exp_res;
    int     v;
    int     k;
    sum     = 0;
    i_ready = (ready_lat == 0);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_cal   = cal;
    for (int n = 1; n <= LAT; n++) begin
      v = int'($urandom_range(0, 63)) - 32;
      if (n >= 3 + DEC * (DISCARD + 1) && (n - 3) % DEC == 0) begin
        k = (n - 3) / DEC - DISCARD - 1;
        if (mode == 0) v = cval;
        else if (mode == 1) v = (k % 2 == 1) ? -32 : 31;
        sum += v;
      end
      i_cic_out = v[BW:0];
      if (n == abort_at) i_abort = 1'b1;
      if (n == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check_eq({tag, "_rst_res"}, o_cic_res, 1);
        check_eq({tag, "_rst_en"}, o_cic_enable, 0);
        check_eq({tag, "_rst_valid"}, o_valid, 0);
        check_eq({tag, "_rst_busy"}, o_busy, 0);
        check_eq({tag, "_rst_result"}, $signed(o_result), 0);
        @(posedge clk); #1;
        rst_n        = 1'b1;
        i_start      = 1'b0;
        i_cal        = 1'b0;
        model_offset = 0;
        last_result  = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq({tag, "_post_busy"}, o_busy, 0);
        check_eq({tag, "_post_res"}, o_cic_res, 1);
        return;
      end
      @(posedge clk); #1;
      i_start = 1'b0;
      i_cal   = 1'b0;
      if (n == abort_at) begin
        i_abort = 1'b0;
        check_eq({tag, "_busy"}, o_busy, 0);
        check_eq({tag, "_en"}, o_cic_enable, 0);
        check_eq({tag, "_valid"}, o_valid, 0);
        check_eq({tag, "_result_kept"}, $signed(o_result), last_result);
        repeat (LAT) @(posedge clk);
        #1;
        check_eq({tag, "_no_valid"}, o_valid, 0);
        return;
      end
      if (n == 1) begin
        check_eq({tag, "_busy_rise"}, o_busy, 1);
        check_eq({tag, "_flush_res"}, o_cic_res, 1);
      end
      if (n == 3) begin
        check_eq({tag, "_settle_res"}, o_cic_res, 0);
        check_eq({tag, "_settle_en"}, o_cic_enable, 1);
      end
      if (n == LAT - 1) check_eq({tag, "_valid_early"}, o_valid, 0);
    end
    if (cal) begin
      check_eq({tag, "_cal_valid"}, o_valid, 0);
      check_eq({tag, "_cal_busy"}, o_busy, 0);
      model_offset = sum;
      return;
    end
    exp_res = clamp(sum - model_offset);
    check_eq({tag, "_valid"}, o_valid, 1);
    check_eq({tag, "_hold_en"}, o_cic_enable, 0);
    check_eq({tag, "_result"}, $signed(o_result), exp_res);
    if (chk_const) check_eq({tag, "_const"}, $signed(o_result), exp_const);
    for (int j = 0; j < ready_lat; j++) begin
      i_start = j[0];
      @(posedge clk); #1;
      check_eq({tag, "_hold_valid"}, o_valid, 1);
      check_eq({tag, "_hold_result"}, $signed(o_result), exp_res);
    end
    i_start = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_valid_drop"}, o_valid, 0);
    check_eq({tag, "_busy_fall"}, o_busy, 0);
    last_result = exp_res;
  endtask

  initial begin
    rst_n     = 1'b0;
    i_start   = 1'b0;
    i_abort   = 1'b0;
    i_cal     = 1'b0;
    i_cic_out = '0;
    i_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("reset_res", o_cic_res, 1);
    check_eq("reset_en", o_cic_enable, 0);
    check_eq("reset_valid", o_valid, 0);
    check_eq("reset_busy", o_busy, 0);
    check_eq("reset_result", $signed(o_result), 0);

    run_conv("const5", 0, 5, 1'b0, 0, 0, 0, 1'b1, 40);
    run_conv("neg32", 0, -32, 1'b0, 0, 0, 0, 1'b1, -256);
    run_conv("alt", 1, 0, 1'b0, 0, 0, 0, 1'b1, -4);
    run_conv("hold", 0, 7, 1'b0, 10, 0, 0, 1'b1, 56);
    run_conv("abort", 0, 9, 1'b0, 0, 60, 0, 1'b0, 0);
    run_conv("after_abort", 0, 2, 1'b0, 0, 0, 0, 1'b1, 16);
    run_conv("reset", 2, 0, 1'b0, 0, 0, 20, 1'b0, 0);
    for (int r = 0; r < 3; r++) begin
      run_conv("rand", 2, 0, 1'b0, int'($urandom_range(0, 3)), 0, 0, 1'b0, 0);
    end
`ifdef CIC_CTRL_OFFSET_CAL_EN
    run_conv("cal3", 0, 3, 1'b1, 0, 0, 0, 1'b0, 0);
    run_conv("ofs5", 0, 5, 1'b0, 0, 0, 0, 1'b1, 16);
    run_conv("cal_m32", 0, -32, 1'b1, 0, 0, 0, 1'b0, 0);
    run_conv("sat31", 0, 31, 1'b0, 0, 0, 0, 1'b1, 255);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
